// File: rtl/fifo_drain_ctrl.sv
// ============================================================================
// fifo_drain_ctrl
// ----------------------------------------------------------------------------
// Read-side controller for a synchronous FIFO with one cycle of read latency.
// It issues fifo_rd_en, captures fifo_data_out on the following edge into a
// 2-entry skid buffer, and presents the words on a valid/ready stream. The
// consumer therefore never has to track the FIFO read latency.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   enable          level: 1 = drain the FIFO, 0 = stop issuing reads
//   err_clr         one-cycle pulse: clears err_underflow and leaves ERR
//   fifo_empty      FIFO empty flag
//   fifo_underflow  FIFO underflow flag (registered in the FIFO)
//   fifo_data_out   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en      FIFO read enable (combinational, depends on m_ready)
//   m_valid         stream valid
//   m_data          stream data (head of the skid buffer)
//   m_ready         stream ready
//   busy            high while in RUN or STOP
//   err_underflow   sticky underflow indication
//   word_cnt        number of words accepted downstream, wraps
// ============================================================================
module fifo_drain_ctrl #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  err_clr,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  err_underflow,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t                state_q,    state_d;
    logic [1:0]            buf_cnt_q,  buf_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [FIFO_WIDTH-1:0] ent0_q,     ent0_d;     // head (oldest) entry
    logic [FIFO_WIDTH-1:0] ent1_q,     ent1_d;
    logic                  err_q,      err_d;
    logic [CNT_WIDTH-1:0]  cnt_q,      cnt_d;

    logic                  pop_s;
    logic                  rd_en_s;
    logic [2:0]            owned_s;

    // A pop needs at least one buffered word, so owned_s cannot go negative.
    assign pop_s   = (buf_cnt_q != 2'd0) & m_ready;
    assign owned_s = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    // Only read when the word is guaranteed a free buffer slot on arrival.
    assign rd_en_s = (state_q == ST_RUN) & ~fifo_empty & (owned_s < 3'd2);

    assign fifo_rd_en    = rd_en_s;
    assign m_valid       = (buf_cnt_q != 2'd0);
    assign m_data        = ent0_q;
    assign busy          = (state_q == ST_RUN) | (state_q == ST_STOP);
    assign err_underflow = err_q;
    assign word_cnt      = cnt_q;

    // Next-state logic for the control FSM and the sticky error flag.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (fifo_underflow) begin
                    state_d = ST_ERR;
                end else if (!enable) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STOP: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (!inflight_q && (buf_cnt_q == 2'd0)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear wins over a simultaneous underflow.
        if (err_clr) begin
            err_d = 1'b0;
        end else if (fifo_underflow) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Skid-buffer update: push the landing word, pop the head, keep order.
    always_comb begin
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        buf_cnt_d  = buf_cnt_q;
        inflight_d = rd_en_s;
        case ({inflight_q, pop_s})
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    ent0_d = fifo_data_out;
                end else begin
                    ent1_d = fifo_data_out;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d    = ent1_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word goes behind any survivor.
                if (buf_cnt_q == 2'd1) begin
                    ent0_d = fifo_data_out;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = fifo_data_out;
                end
            end
            default: begin
                buf_cnt_d = buf_cnt_q;
            end
        endcase
    end

    // Accepted-word counter; wraps naturally at 2^CNT_WIDTH.
    always_comb begin
        if (pop_s) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            buf_cnt_q  <= 2'd0;
            inflight_q <= 1'b0;
            ent0_q     <= {FIFO_WIDTH{1'b0}};
            ent1_q     <= {FIFO_WIDTH{1'b0}};
            err_q      <= 1'b0;
            cnt_q      <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            buf_cnt_q  <= buf_cnt_d;
            inflight_q <= inflight_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl. A queue-based FIFO sits upstream of the DUT; a
// reference model tracks, in plain counts, how many words the controller owns
// (read but not yet accepted) and the order words must appear downstream.
module tb_fifo_drain_ctrl;

    localparam int W  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          err_clr;
    logic          fifo_empty;
    logic          fifo_underflow;
    logic [W-1:0]  fifo_data_out;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready;
    logic          busy;
    logic          err_underflow;
    logic [CW-1:0] word_cnt;

    always #5 clk = ~clk;

    fifo_drain_ctrl #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .err_clr        (err_clr),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .busy           (busy),
        .err_underflow  (err_underflow),
        .word_cnt       (word_cnt)
    );

    // Upstream FIFO contents and expected downstream order.
    logic [W-1:0]  fq[$];
    logic [W-1:0]  exp_q[$];
    // Reference model state.
    int            owned;      // words read from the FIFO, not yet accepted
    bit            last_rd;    // a read was issued last cycle (word in flight)
    bit            m_run;      // controller expected to be issuing reads
    bit            m_err;      // controller expected to be parked in error
    bit            m_flag;     // expected sticky underflow flag
    logic [CW-1:0] exp_cnt;
    bit            force_uf;
    int            vectors;
    int            miscompares;
    int            rd_total;
    int            pop_total;
    int            cyc;
    int            max_owned;

    task automatic preload(input int n, input bit rnd);
        logic [W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? W'($urandom) : W'(i + 1);
            fq.push_back(w);
            exp_q.push_back(w);
        end
        fifo_empty = (fq.size() == 0);
    endtask

    // One clock cycle: check at the falling edge, advance the model, then
    // update the upstream FIFO just after the rising edge.
    task automatic cycle();
        bit exp_valid, exp_pop, exp_rd, s_rd, n_run, n_err, uf_next;
        @(negedge clk);
        exp_valid = (owned - int'(last_rd)) > 0;
        exp_pop   = exp_valid && (m_ready === 1'b1);
        exp_rd    = m_run && (fq.size() != 0) && ((owned - int'(exp_pop)) < 2);
        s_rd      = (fifo_rd_en === 1'b1);

        vectors++;
        if (fifo_rd_en !== exp_rd) begin
            miscompares++;
            $display("FAIL rd_en: got %b expected %b at %0t", fifo_rd_en, exp_rd, $time);
        end
        vectors++;
        if (m_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL m_valid: got %b expected %b at %0t", m_valid, exp_valid, $time);
        end
        if (exp_valid && exp_q.size() != 0) begin
            vectors++;
            if (m_data !== exp_q[0]) begin
                miscompares++;
                $display("FAIL m_data: got %h expected %h at %0t", m_data, exp_q[0], $time);
            end
        end
        vectors++;
        if (word_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL word_cnt: got %0d expected %0d at %0t", word_cnt, exp_cnt, $time);
        end
        vectors++;
        if (err_underflow !== m_flag) begin
            miscompares++;
            $display("FAIL err_underflow: got %b expected %b at %0t", err_underflow, m_flag, $time);
        end

        if (exp_pop) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            exp_cnt = exp_cnt + 16'd1;
            owned--;
            pop_total++;
        end
        if (exp_rd) owned++;
        if (s_rd) rd_total++;
        last_rd = exp_rd;
        if (owned > max_owned) max_owned = owned;
        n_err  = err_clr ? 1'b0 : (m_err || (m_run && fifo_underflow));
        n_run  = enable && !m_err && !(m_run && fifo_underflow);
        m_flag = err_clr ? 1'b0 : (m_flag || fifo_underflow);
        m_err  = n_err;
        m_run  = n_run;

        @(posedge clk);
        #1;
        cyc++;
        err_clr = 1'b0;
        uf_next = 1'b0;
        if (s_rd) begin
            if (fq.size() != 0) fifo_data_out = fq.pop_front();
            else uf_next = 1'b1;
        end
        fifo_underflow = uf_next | force_uf;
        force_uf       = 1'b0;
        fifo_empty     = (fq.size() == 0);
    endtask

    task automatic drain_wait(input string name, input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || owned != 0) && n < bound) begin
            cycle();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0 || owned != 0) begin
            miscompares++;
            $display("FAIL %s timeout: %0d words still expected", name, exp_q.size());
        end
    endtask

    task automatic model_init();
        fq.delete();
        exp_q.delete();
        owned = 0; last_rd = 1'b0; m_run = 1'b0; m_err = 1'b0; m_flag = 1'b0;
        exp_cnt = '0; force_uf = 1'b0; max_owned = 0;
        fifo_data_out = '0; fifo_empty = 1'b1; fifo_underflow = 1'b0;
        enable = 1'b0; err_clr = 1'b0; m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        model_init();
        #2 rst_n = 1'b0;
        #2;
        vectors++;
        if ({fifo_rd_en, m_valid, busy, err_underflow} !== 4'b0000 || m_data !== 16'h0000 || word_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state: got rd=%b v=%b busy=%b err=%b data=%h cnt=%0d expected all zero",
                     fifo_rd_en, m_valid, busy, err_underflow, m_data, word_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_stream();
        int first_rd = -1, last_rd_c = -1, first_pop = -1, last_pop = -1;
        int r0 = rd_total, p0 = pop_total, r, p;
        preload(8, 1'b0);
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            r = rd_total; p = pop_total;
            cycle();
            if (rd_total > r) begin
                if (first_rd < 0) first_rd = cyc;
                last_rd_c = cyc;
            end
            if (pop_total > p) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
        vectors++;
        if (rd_total - r0 != 8 || last_rd_c - first_rd != 7) begin
            miscompares++;
            $display("FAIL stream_rd: got %0d pulses over %0d cycles expected 8 over 8", rd_total - r0, last_rd_c - first_rd + 1);
        end
        vectors++;
        if (pop_total - p0 != 8 || first_pop - first_rd != 2 || last_pop - first_pop != 7) begin
            miscompares++;
            $display("FAIL stream_out: got %0d words, lag %0d, span %0d expected 8, 2, 7",
                     pop_total - p0, first_pop - first_rd, last_pop - first_pop);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_busy: got %b expected 1", busy);
        end
        enable = 1'b0;
        repeat (3) cycle();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_stall();
        int r0 = rd_total, p0 = pop_total;
        preload(8, 1'b1);
        m_ready = 1'b0;
        enable  = 1'b1;
        repeat (10) cycle();
        vectors++;
        if (rd_total - r0 != 2) begin
            miscompares++;
            $display("FAIL stall_rd: got %0d pulses expected 2", rd_total - r0);
        end
        m_ready = 1'b1;
        drain_wait("stall_drain", 40);
        vectors++;
        if (pop_total - p0 != 8) begin
            miscompares++;
            $display("FAIL stall_count: got %0d words expected 8", pop_total - p0);
        end
        enable = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_random_ready();
        int p0 = pop_total;
        int n = 0;
        max_owned = 0;
        preload(8, 1'b1);
        enable = 1'b1;
        while ((exp_q.size() != 0 || owned != 0) && n < 200) begin
            m_ready = ($urandom_range(0, 1) == 1);
            cycle();
            n++;
        end
        vectors++;
        if (pop_total - p0 != 8 || max_owned > 2) begin
            miscompares++;
            $display("FAIL random_ready: got %0d words, peak owned %0d expected 8, <=2", pop_total - p0, max_owned);
        end
        m_ready = 1'b1;
        enable  = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_enable_drop();
        int r0 = rd_total, p0 = pop_total;
        preload(8, 1'b0);
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (rd_total - r0 == 2) break;
        end
        // Drop enable during the cycle that carries the third read.
        enable = 1'b0;
        repeat (15) cycle();
        vectors++;
        if (rd_total - r0 != 3 || pop_total - p0 != 3) begin
            miscompares++;
            $display("FAIL drop_count: got %0d reads %0d words expected 3 and 3", rd_total - r0, pop_total - p0);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_busy: got %b expected 0", busy);
        end
        enable = 1'b1;
        drain_wait("drop_resume", 40);
        vectors++;
        if (pop_total - p0 != 8) begin
            miscompares++;
            $display("FAIL drop_resume_count: got %0d words expected 8", pop_total - p0);
        end
        enable = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic test_underflow_and_single();
        int r0, p0;
        enable = 1'b1;
        repeat (2) cycle();
        force_uf = 1'b1;
        cycle();
        cycle();
        vectors++;
        if (err_underflow !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_set: got err=%b busy=%b expected 1 0", err_underflow, busy);
        end
        preload(1, 1'b1);
        r0 = rd_total;
        repeat (4) cycle();
        vectors++;
        if (rd_total != r0) begin
            miscompares++;
            $display("FAIL err_no_reads: got %0d reads expected 0", rd_total - r0);
        end
        err_clr = 1'b1;
        enable  = 1'b0;
        cycle();
        vectors++;
        if (err_underflow !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: got err=%b busy=%b expected 0 0", err_underflow, busy);
        end
        cycle();
        // One word in the FIFO must produce exactly one read.
        r0 = rd_total; p0 = pop_total;
        enable = 1'b1;
        repeat (8) cycle();
        vectors++;
        if (rd_total - r0 != 1 || pop_total - p0 != 1) begin
            miscompares++;
            $display("FAIL single_word: got %0d reads %0d words expected 1 and 1", rd_total - r0, pop_total - p0);
        end
        enable = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_async_reset();
        logic exp_pre;
        preload(8, 1'b1);
        m_ready = 1'b0;
        enable  = 1'b1;
        repeat (6) cycle();
        m_ready = 1'b1;
        #1;
        exp_pre = m_run && (fq.size() != 0) && ((owned - 1) < 2);
        vectors++;
        if (m_valid !== 1'b1 || fifo_rd_en !== exp_pre || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL prereset: got v=%b rd=%b busy=%b expected 1 %b 1", m_valid, fifo_rd_en, busy, exp_pre);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || word_cnt !== 16'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b rd=%b cnt=%0d busy=%b expected 0 0 0 0",
                     m_valid, fifo_rd_en, word_cnt, busy);
        end
        model_init();
        #1 rst_n = 1'b1;
        preload(3, 1'b1);
        enable = 1'b1;
        drain_wait("post_reset", 30);
        enable = 1'b0;
        repeat (3) cycle();
    endtask

    initial begin
        vectors = 0; miscompares = 0; rd_total = 0; pop_total = 0; cyc = 0;
        test_reset();
        test_stream();
        test_stall();
        test_random_ready();
        test_enable_drop();
        test_underflow_and_single();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/fifo_drain_ctrl.md
Name: fifo_drain_ctrl

Overview:
Read-side controller that sits directly downstream of the synchronous FIFO (FIFO_WIDTH=16, FIFO_DEPTH=8). It drives the FIFO rd_en, captures data_out one cycle later, and presents the words on a valid/ready stream through a 2-entry skid buffer. It reports busy, a sticky underflow error and a transferred-word count. The consumer side therefore never has to track FIFO read latency.

Parameters:
FIFO_WIDTH, 16, data width; matches the FIFO data_in/data_out width.
CNT_WIDTH, 16, width of word_cnt.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  level; 1 = drain the FIFO, 0 = stop issuing reads.
err_clr  input  1  one-cycle pulse; clears err_underflow and leaves ERR.
fifo_empty  input  1  FIFO empty flag.
fifo_underflow  input  1  FIFO underflow flag; registered, asserted the cycle after an illegal read.
fifo_data_out  input  FIFO_WIDTH  FIFO read data; valid the cycle after rd_en.
fifo_rd_en  output  1  FIFO read enable.
m_valid  output  1  stream valid.
m_data  output  FIFO_WIDTH  stream data.
m_ready  input  1  stream ready.
busy  output  1  high in RUN or STOP.
err_underflow  output  1  sticky underflow indication.
word_cnt  output  CNT_WIDTH  count of words accepted downstream; wraps.

Behaviour:
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, busy=0, err_underflow=0, word_cnt=0. Reset also sets state=IDLE, buf_cnt=0, inflight=0.
- Reset mid-operation: all of the above take effect immediately. Any in-flight read is discarded.
- Read latency: fifo_rd_en at cycle N means fifo_data_out is captured at the edge ending cycle N+1. inflight is a 1-bit register equal to fifo_rd_en delayed by one cycle.
- pop = m_valid & m_ready.
- Issue rule (combinational): fifo_rd_en = (state==RUN) & !fifo_empty & (buf_cnt + inflight - pop < 2).
  - fifo_rd_en depends combinationally on m_ready.
  - With m_ready held at 1, this sustains one word per cycle.
- Skid buffer: 2-entry FIFO, oldest entry first.
  - m_valid = (buf_cnt != 0); m_data = head entry.
  - A push (inflight) and a pop in the same cycle leave buf_cnt unchanged and preserve order.
  - m_data is stable while m_valid=1 and m_ready=0.
  - The issue rule guarantees buf_cnt never exceeds 2 and a push never targets a full buffer.
- word_cnt increments by 1 on each pop and wraps from 2^CNT_WIDTH-1 to 0.
- State machine:
  - IDLE: enable=1 -> RUN.
  - RUN: reads are issued per the issue rule.
    - fifo_underflow=1 -> ERR.
    - enable=0 -> STOP.
  - STOP: no new reads. The in-flight word still lands in the buffer. When inflight=0 and buf_cnt=0 -> IDLE. If enable rises before that -> RUN.
  - ERR: set err_underflow=1 and issue no reads. The buffer continues to drain downstream. On err_clr=1 -> IDLE and err_underflow=0 (err_clr takes priority over a simultaneous underflow).
  - fifo_underflow seen in any state other than RUN still sets err_underflow; the state is unchanged.
- busy = (state==RUN) | (state==STOP).
- Empty boundary: fifo_empty is re-evaluated every cycle. A FIFO holding one word gets exactly one rd_en pulse.
- enable dropping in the same cycle as an rd_en: that read completes and its word is delivered.

Test Plan:
- Preload FIFO with 0x0001..0x0008, enable=1, m_ready=1 -> fifo_rd_en high for 8 consecutive cycles; m_data 0x0001..0x0008 on consecutive cycles starting 2 cycles after the first rd_en; word_cnt=8; fifo_rd_en=0 once empty.
- Preload 8 words, m_ready=0 for 10 cycles then 1 -> exactly 2 rd_en pulses, m_data held at 0x0001 with m_valid=1 throughout the stall, then all 8 words in order, none lost or duplicated.
- Random m_ready (50%) during streaming of 8 words -> output order 0x0001..0x0008, buf_cnt never exceeds 2, word_cnt=8.
- Drop enable during streaming after the 3rd rd_en -> exactly 3 words output, state returns to IDLE and busy=0 after the buffer empties; re-enable -> remaining 5 words follow.
- Force fifo_underflow=1 for one cycle in RUN -> err_underflow=1 next cycle, fifo_rd_en stays 0; err_clr pulse -> err_underflow=0, state IDLE.
- Assert rst_n=0 asynchronously with 2 words buffered -> m_valid, fifo_rd_en, word_cnt and busy go to 0 immediately.
